// File: rtl/bcd_digit_scan.sv
// Binary-to-BCD converter (shift-add-3, one bit per clock) feeding a time-multiplexed
// multi-digit display bus with optional leading-zero blanking.
module bcd_digit_scan #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  value_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [3:0]        bcd_o,
  output logic [DIGITS-1:0] digit_en_o
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Conversion state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_adj;
  logic             ovf_pend_q, ovf_pend_d;
  logic             overflow_q, overflow_d;
  logic [BCD_W-1:0] disp_q, disp_d;

  // Scan state
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_dly_q;
  logic [3:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;

  function automatic logic [SR_W-1:0] add3(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++)
      if (r[BIN_W+4*k +: 4] >= 4'd5) r[BIN_W+4*k +: 4] = r[BIN_W+4*k +: 4] + 4'd3;
    return r;
  endfunction

  // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
  function automatic logic [3:0] digit_code(input logic [BCD_W-1:0] d,
                                            input logic [IDX_W-1:0] idx);
    logic lead;
    lead = (BLANK_LZ != 0) && (idx != '0);
    for (int k = 0; k < DIGITS; k++)
      if (IDX_W'(k) >= idx && d[4*k +: 4] != 4'd0) lead = 1'b0;
    return lead ? 4'hF : d[4*idx +: 4];
  endfunction

  assign sr_adj = add3(sr_q);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          sr_d       = {{BCD_W{1'b0}}, value_i};
          cnt_d      = '0;
          ovf_pend_d = (64'(value_i) >= LIMIT);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d = {sr_adj[SR_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_COMMIT;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      S_COMMIT: begin
        disp_d     = ovf_pend_q ? ALL_NINES : sr_q[SR_W-1 -: BCD_W];
        overflow_d = ovf_pend_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    bcd_d = digit_code(disp_q, idx_q);
    for (int k = 0; k < DIGITS; k++) digit_en_d[k] = (idx_dly_q == IDX_W'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      idx_dly_q  <= '0;
      bcd_q      <= 4'hF;
      digit_en_q <= '0;
    end else begin
      // NOTE: registers use non-blocking assignment so all of them update from pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      idx_dly_q  <= idx_q;
      bcd_q      <= bcd_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_COMMIT);
  // Overflow is presented together with the done pulse, then held by overflow_q.
  assign overflow_o = done_o ? ovf_pend_q : overflow_q;
  assign bcd_o      = bcd_q;
  assign digit_en_o = digit_en_q;

endmodule
